// File: rtl/hog_svm_lite_ctrl_if.sv
// Xillybus Lite user-side register bus: host strobes, registered read data and interrupt level.
// Carries no clock; the attached modules share bus_clk.
interface hog_svm_lite_ctrl_if;
    logic [31:0] user_addr;
    logic        user_wren;
    logic [3:0]  user_wstrb;
    logic [31:0] user_wr_data;
    logic        user_rden;
    logic [31:0] user_rd_data;
    logic        user_irq;

    modport master (
        output user_addr, user_wren, user_wstrb, user_wr_data, user_rden,
        input  user_rd_data, user_irq
    );

    modport slave (
        input  user_addr, user_wren, user_wstrb, user_wr_data, user_rden,
        output user_rd_data, user_irq
    );
endinterface

// File: rtl/hog_svm_lite_ctrl.sv
// Register slave that configures, starts and watches the HOG/SVM core; latches result and raises irq.
// Latency: read data 1 cycle after rden; core_start 1 cycle after START write; irq 1 cycle after event.
// Backpressure: none; every write/read strobe is accepted in its cycle, START/ABORT ignored in illegal states.
module hog_svm_lite_ctrl #(
    parameter logic [31:0] VERSION = 32'h4853_0001,
    parameter int          CNT_W   = 32
) (
    input  logic                 bus_clk,
    input  logic                 bus_rst_n,
    hog_svm_lite_ctrl_if.slave   lite,
    output logic                 core_start,
    output logic                 core_abort,
    output logic [31:0]          cfg_frame_base,
    output logic [31:0]          cfg_threshold,
    input  logic                 core_done,
    input  logic [31:0]          core_result,
    input  logic                 core_hit
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BUSY  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic              auto_en;
    logic [1:0]        irq_en, irq_stat;
    logic [31:0]       frame_base, threshold, result;
    logic [CNT_W-1:0]  timeout, cnt, cycles;
    logic [15:0]       job_count;
    logic              last_hit, to_flag;
    logic [31:0]       rd_dat, rd_mux;
    logic              irq;

    logic [4:0]        idx;
    logic              ctrl_wr, start_wr, abort_wr;
    logic [CNT_W-1:0]  cnt_inc;
    logic              to_hit, job_start;
    logic              abort_nxt, set_done, set_err;
    logic [1:0]        irq_clr, irq_stat_nxt, irq_en_nxt;
    logic [31:0]       wr_merged_fb, wr_merged_thr, wr_merged_to;

    wire unused_addr = &{1'b0, lite.user_addr[31:7], lite.user_addr[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[8*b +: 8] = dat[8*b +: 8];
        return res;
    endfunction

    assign idx      = lite.user_addr[6:2];
    assign ctrl_wr  = lite.user_wren && (idx == 5'd0) && lite.user_wstrb[0];
    assign start_wr = ctrl_wr && lite.user_wr_data[0];
    assign abort_wr = ctrl_wr && lite.user_wr_data[1];

    assign wr_merged_fb  = merge(frame_base, lite.user_wr_data, lite.user_wstrb);
    assign wr_merged_thr = merge(threshold,  lite.user_wr_data, lite.user_wstrb);
    assign wr_merged_to  = merge(32'(timeout), lite.user_wr_data, lite.user_wstrb);

    // cnt_inc is the count of the current BUSY cycle, so the first BUSY cycle counts as 1
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    assign to_hit  = (timeout != '0) && (cnt_inc == timeout);

    always_comb begin
        state_nxt = state;
        abort_nxt = 1'b0;
        set_done  = 1'b0;
        set_err   = 1'b0;
        case (state)
            S_IDLE:  if (start_wr) state_nxt = S_START;
            S_START: state_nxt = S_BUSY;
            S_BUSY: begin
                if (core_done) begin
                    state_nxt = S_DONE;
                    set_done  = 1'b1;
                end else if (abort_wr) begin
                    state_nxt = S_IDLE;
                    abort_nxt = 1'b1;
                end else if (to_hit) begin
                    state_nxt = S_ERR;
                    abort_nxt = 1'b1;
                    set_err   = 1'b1;
                end
            end
            S_DONE:  state_nxt = (start_wr || auto_en) ? S_START : S_IDLE;
            S_ERR: begin
                if (start_wr)      state_nxt = S_START;
                else if (abort_wr) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign job_start = (state_nxt == S_START) && (state != S_START);

    // a set event in the same cycle as a W1C of that bit wins
    always_comb begin
        irq_clr = 2'b00;
        if (lite.user_wren && (idx == 5'd3) && lite.user_wstrb[0])
            irq_clr = lite.user_wr_data[1:0];
        irq_stat_nxt = (irq_stat & ~irq_clr) | {set_err, set_done};
        irq_en_nxt   = irq_en;
        if (lite.user_wren && (idx == 5'd2) && lite.user_wstrb[0])
            irq_en_nxt = lite.user_wr_data[1:0];
    end

    always_comb begin
        rd_mux = '0;
        case (idx)
            5'd0:    rd_mux = {29'b0, auto_en, 2'b00};
            5'd1:    rd_mux = {27'b0, to_flag, last_hit, state};
            5'd2:    rd_mux = {30'b0, irq_en};
            5'd3:    rd_mux = {30'b0, irq_stat};
            5'd4:    rd_mux = frame_base;
            5'd5:    rd_mux = threshold;
            5'd6:    rd_mux = result;
            5'd7:    rd_mux = 32'(cycles);
            5'd8:    rd_mux = 32'(timeout);
            5'd9:    rd_mux = {16'b0, job_count};
            5'd10:   rd_mux = VERSION;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            state          <= S_IDLE;
            auto_en        <= 1'b0;
            irq_en         <= '0;
            irq_stat       <= '0;
            frame_base     <= '0;
            threshold      <= '0;
            result         <= '0;
            timeout        <= '0;
            cnt            <= '0;
            cycles         <= '0;
            job_count      <= '0;
            last_hit       <= 1'b0;
            to_flag        <= 1'b0;
            rd_dat         <= '0;
            irq            <= 1'b0;
            core_abort     <= 1'b0;
            cfg_frame_base <= '0;
            cfg_threshold  <= '0;
        end else begin
            state      <= state_nxt;
            core_abort <= abort_nxt;
            irq_stat   <= irq_stat_nxt;
            irq_en     <= irq_en_nxt;
            irq        <= |(irq_stat_nxt & irq_en_nxt);

            if (ctrl_wr) auto_en <= lite.user_wr_data[2];
            if (lite.user_wren && idx == 5'd4) frame_base <= wr_merged_fb;
            if (lite.user_wren && idx == 5'd5) threshold  <= wr_merged_thr;
            if (lite.user_wren && idx == 5'd8) timeout    <= wr_merged_to[CNT_W-1:0];

            if (job_start) begin
                cfg_frame_base <= frame_base;
                cfg_threshold  <= threshold;
                cnt            <= '0;
                to_flag        <= 1'b0;
            end else if (state == S_BUSY) begin
                cnt <= cnt_inc;
            end

            if (set_err) to_flag <= 1'b1;
            if (set_done) begin
                result    <= core_result;
                last_hit  <= core_hit;
                cycles    <= cnt_inc;
                job_count <= job_count + 16'd1;
            end

            if (lite.user_rden) rd_dat <= rd_mux;
        end
    end

    assign core_start        = (state == S_START);
    assign lite.user_rd_data = rd_dat;
    assign lite.user_irq     = irq;

endmodule
